// File: rtl/pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// pipe_fetch_queue
//
// Instruction-fetch front end. Holds the fetch PC and drives the
// combinational instruction ROM. Fetched {pc, instr} pairs are buffered in a
// DEPTH-entry prefetch queue that decode drains through a valid/ready
// handshake. A single redirect port (branch/jump/jr/exception) flushes the
// queue and restarts fetch at the new address.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   defined   - when the queue is empty and fetch is enabled, the ROM word is
//               presented on id_* in the same cycle (zero-latency hit).
//   undefined - id_* come only from registered queue storage.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   fetch_en       in   1 = fetch allowed; 0 = hold fetch pc, no push
//   imem_addr      out  ROM address (= fetch pc)
//   imem_data      in   ROM word, combinational from imem_addr
//   redirect_valid in   flush queue and load redirect_pc
//   redirect_pc    in   new fetch address, bits[1:0] ignored
//   id_valid       out  head entry valid
//   id_ready       in   decode accepts head this cycle
//   id_instr       out  head instruction (0 when id_valid=0)
//   id_pc          out  head PC (0 when id_valid=0)
//   id_pc_plus_4   out  head PC+4 with kernel bit kept (0 when id_valid=0)
//   occupancy      out  number of entries held
// ---------------------------------------------------------------------------
module pipe_fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [DATA_W-1:0]          id_instr,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [ADDR_W-1:0]          id_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  localparam logic [OCC_W-1:0]  OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE    = OCC_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [ADDR_W-4:0] OFF_ONE    = (ADDR_W-3)'(1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  // Word-offset increment: the kernel bit (MSB) is preserved and the offset
  // field wraps within its own range, so a kernel PC never leaves kernel space.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-4:0] off;
    off = pc[ADDR_W-2:2] + OFF_ONE;
    return {pc[ADDR_W-1], off, 2'b00};
  endfunction

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic head_valid_s;
  logic bypass_s;
  logic bypass_take_s;
  logic q_pop_s;
  logic fetch_adv_s;
  logic q_push_s;

  assign head_valid_s = (occ_q != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass_s = ~head_valid_s & fetch_en & ~redirect_valid;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed word that decode accepts is consumed without touching storage.
  assign bypass_take_s = bypass_s & id_ready;
  assign q_pop_s       = head_valid_s & id_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign fetch_adv_s   = fetch_en & ~redirect_valid & ((occ_q != OCC_FULL) | q_pop_s);
  assign q_push_s      = fetch_adv_s & ~bypass_take_s;

  // Next-state computation for fetch PC, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
    end else begin
      if (fetch_adv_s) begin
        fetch_pc_d = pc_incr(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (q_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (q_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({q_push_s, q_pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Queue storage: written with the current fetch PC and ROM word on push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (q_push_s) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_data;
    end else begin
      pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
      instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
    end
  end

  assign imem_addr = fetch_pc_q;
  assign occupancy = occ_q;

  // Decode-side view: queue head, the bypassed ROM word, or all-zero nop.
  always_comb begin
    id_valid     = 1'b0;
    id_instr     = '0;
    id_pc        = '0;
    id_pc_plus_4 = '0;
    if (head_valid_s) begin
      id_valid     = 1'b1;
      id_instr     = instr_mem_q[rd_ptr_q];
      id_pc        = pc_mem_q[rd_ptr_q];
      id_pc_plus_4 = pc_incr(pc_mem_q[rd_ptr_q]);
    end else if (bypass_s) begin
      id_valid     = 1'b1;
      id_instr     = imem_data;
      id_pc        = fetch_pc_q;
      id_pc_plus_4 = pc_incr(fetch_pc_q);
    end else begin
      id_valid     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_pipe_fetch_queue
//
// Directed bench for pipe_fetch_queue in its default build (bypass disabled).
// The ROM model returns the word index of the address: data = addr[30:2].
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_pipe_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = {3'b000, imem_addr[30:2]};

  pipe_fetch_queue #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr, 32'd0);
    chk({tag, "_pc"}, id_pc, 32'd0);
    chk({tag, "_pc4"}, id_pc_plus_4, 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b1;

    // Reset state
    #12;
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk_idle("rst");
    reset = 1'b1;

    // 1: streaming, one word per cycle from the first edge after release
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_valid", {31'd0, id_valid}, 32'd1);
      chk("s1_pc", id_pc, 32'h8000_0000 + 32'(4 * k));
      chk("s1_instr", id_instr, 32'(k));
      chk("s1_pc4", id_pc_plus_4, 32'h8000_0004 + 32'(4 * k));
      chk("s1_occ", {29'd0, occupancy}, 32'd1);
    end

    // Mid-operation reset discards the queue at once
    reset = 1'b0;
    #1;
    chk("mrst_addr", imem_addr, 32'h8000_0000);
    chk("mrst_occ", {29'd0, occupancy}, 32'd0);
    chk_idle("mrst");

    // 2: decode stalled for 10 cycles, queue saturates
    id_ready = 1'b0;
    reset    = 1'b1;
    repeat (10) tick();
    chk("s2_occ", {29'd0, occupancy}, 32'd4);
    chk("s2_addr", imem_addr, 32'h8000_0010);
    chk("s2_pc", id_pc, 32'h8000_0000);
    chk("s2_instr", id_instr, 32'd0);
    id_ready = 1'b1;
    tick();
    chk("s2_pp_occ", {29'd0, occupancy}, 32'd4);
    chk("s2_pp_addr", imem_addr, 32'h8000_0014);
    chk("s2_pp_pc", id_pc, 32'h8000_0004);
    id_ready = 1'b0;

    // 3: redirect while full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0403;
    tick();
    chk("s3_occ", {29'd0, occupancy}, 32'd0);
    chk("s3_addr", imem_addr, 32'h0000_0400);
    chk_idle("s3");
    redirect_valid = 1'b0;
    tick();
    chk("s3_occ1", {29'd0, occupancy}, 32'd1);
    chk("s3_pc", id_pc, 32'h0000_0400);
    chk("s3_instr", id_instr, 32'h0000_0100);
    chk("s3_pc4", id_pc_plus_4, 32'h0000_0404);

    // 4: redirect and pop in the same cycle
    tick();
    chk("s4_occ2", {29'd0, occupancy}, 32'd2);
    chk("s4_addr", imem_addr, 32'h0000_0408);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0800;
    #1;
    chk("s4_pop_valid", {31'd0, id_valid}, 32'd1);
    chk("s4_pop_pc", id_pc, 32'h0000_0400);
    tick();
    chk("s4_fl_occ", {29'd0, occupancy}, 32'd0);
    chk("s4_fl_valid", {31'd0, id_valid}, 32'd0);
    chk("s4_fl_addr", imem_addr, 32'h0000_0800);
    redirect_valid = 1'b0;
    tick();
    chk("s4_new_pc", id_pc, 32'h0000_0800);
    chk("s4_new_occ", {29'd0, occupancy}, 32'd1);
    tick();
    chk("s4_next_pc", id_pc, 32'h0000_0804);
    chk("s4_next_instr", id_instr, 32'h0000_0201);

    // 5: offset wrap keeps kernel bit; fetch_en=0 drains with frozen PC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    chk("s5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("s5_occ", {29'd0, occupancy}, 32'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    tick();
    chk("s5_wrap_addr", imem_addr, 32'h8000_0000);
    chk("s5_wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("s5_wrap_pc4", id_pc_plus_4, 32'h8000_0000);
    chk("s5_wrap_instr", id_instr, 32'h1FFF_FFFF);
    repeat (2) tick();
    chk("s5_fill_occ", {29'd0, occupancy}, 32'd3);
    chk("s5_fill_addr", imem_addr, 32'h8000_0008);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick();
    chk("s5_d1_occ", {29'd0, occupancy}, 32'd2);
    chk("s5_d1_pc", id_pc, 32'h8000_0000);
    chk("s5_d1_addr", imem_addr, 32'h8000_0008);
    tick();
    chk("s5_d2_occ", {29'd0, occupancy}, 32'd1);
    chk("s5_d2_pc", id_pc, 32'h8000_0004);
    tick();
    chk("s5_d3_occ", {29'd0, occupancy}, 32'd0);
    chk_idle("s5_d3");
    tick();
    chk("s5_hold_occ", {29'd0, occupancy}, 32'd0);
    chk("s5_hold_addr", imem_addr, 32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    chk("s5_rd_addr", imem_addr, 32'h0000_0100);
    chk("s5_rd_occ", {29'd0, occupancy}, 32'd0);
    redirect_valid = 1'b0;

    // 6: empty queue, fetch enabled -> head appears one cycle later
    fetch_en = 1'b1;
    #1;
    chk("s6_c0_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("s6_c1_valid", {31'd0, id_valid}, 32'd1);
    chk("s6_c1_instr", id_instr, 32'h0000_0040);
    chk("s6_c1_pc", id_pc, 32'h0000_0100);
    chk("s6_c1_occ", {29'd0, occupancy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
